// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - md_sel op codes, latency defaults and FSM states for md_sched.
// Optional multiply-accumulate ops are decoded only when MDU_MADD_EN is defined.
package md_sched_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU: is_mul_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul_op = 1'b1;
`endif
      default: is_mul_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational product/quotient/accumulate result for md_sched.
// Multiply-accumulate variants are built only when MDU_MADD_EN is defined.
module md_arith
  import md_sched_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] pend_hi,
  output logic [31:0] pend_lo
);

  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [63:0] w_res;
  logic [31:0] w_uden;
  logic [31:0] w_num_mag;
  logic [31:0] w_den_mag;
  logic [31:0] w_mq;
  logic [31:0] w_mr;
  logic [31:0] w_sq;
  logic [31:0] w_sr;

  // Low 64 bits of a sign-extended product equal the signed 32x32 product.
  assign w_sprod = {{32{d1[31]}}, d1} * {{32{d2[31]}}, d2};
  assign w_uprod = {32'd0, d1} * {32'd0, d2};

  // Signed divide through magnitudes so 0x80000000 / -1 wraps cleanly; zero divisor is masked.
  assign w_uden    = (d2 == 32'd0) ? 32'd1 : d2;
  assign w_num_mag = d1[31] ? (32'd0 - d1) : d1;
  assign w_den_mag = d2[31] ? (32'd0 - d2) : w_uden;
  assign w_mq      = w_num_mag / w_den_mag;
  assign w_mr      = w_num_mag % w_den_mag;
  assign w_sq      = (d1[31] ^ d2[31]) ? (32'd0 - w_mq) : w_mq;
  assign w_sr      = d1[31] ? (32'd0 - w_mr) : w_mr;

  always_comb begin
    w_res = {hi, lo};
    case (op)
      OP_MULT:  w_res = w_sprod;
      OP_MULTU: w_res = w_uprod;
      OP_DIV:   if (d2 != 32'd0) w_res = {w_sr, w_sq};
      OP_DIVU:  if (d2 != 32'd0) w_res = {d1 % w_uden, d1 / w_uden};
`ifdef MDU_MADD_EN
      OP_MADD:  w_res = {hi, lo} + w_sprod;
      OP_MADDU: w_res = {hi, lo} + w_uprod;
      OP_MSUB:  w_res = {hi, lo} - w_sprod;
      OP_MSUBU: w_res = {hi, lo} - w_uprod;
`endif
      default:  w_res = {hi, lo};
    endcase
  end

  assign pend_hi = w_res[63:32];
  assign pend_lo = w_res[31:0];

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - E-stage multiply/divide sequencer owning HI/LO, busy counter and D-stage stall.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_sel,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic        D_md_use,
  output logic        md_stall,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_start;
  logic [31:0] w_pend_hi;
  logic [31:0] w_pend_lo;

  assign w_is_mul = is_mul_op(md_sel);
  assign w_is_div = is_div_op(md_sel);
  assign w_start  = (w_is_mul | w_is_div) & (r_state == ST_IDLE);

  md_arith u_arith (
    .op      (md_sel),
    .d1      (d1),
    .d2      (d2),
    .hi      (r_hi),
    .lo      (r_lo),
    .pend_hi (w_pend_hi),
    .pend_lo (w_pend_lo)
  );

  // Result is computed at launch; the busy window only models pipeline latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_mul || w_is_div) begin
            r_pend_hi <= w_pend_hi;
            r_pend_lo <= w_pend_lo;
            r_cnt     <= w_is_mul ? MULT_CNT : DIV_CNT;
            r_state   <= w_is_mul ? ST_MUL : ST_DIV;
            r_busy    <= 1'b1;
          end else if (md_sel == OP_MTHI) begin
            r_hi <= d1;
          end else if (md_sel == OP_MTLO) begin
            r_lo <= d1;
          end
        end
        ST_MUL, ST_DIV: begin
          if (r_cnt == 4'd0) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign md_stall = D_md_use & (w_start | r_busy);
  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;

  always_comb begin
    md_out = 32'd0;
    case (md_sel)
      OP_MFHI: md_out = r_hi;
      OP_MFLO: md_out = r_lo;
      default: md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed self-checking bench for md_sched (MDU_MADD_EN selects the accumulate checks).
module tb_md_sched;
  import md_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  md_sel = 4'd0;
  logic [31:0] d1 = 32'd0;
  logic [31:0] d2 = 32'd0;
  logic        D_md_use = 1'b0;
  logic        md_stall;
  logic        busy;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  md_sched dut (
    .clk      (clk),
    .reset    (reset),
    .md_sel   (md_sel),
    .d1       (d1),
    .d2       (d2),
    .D_md_use (D_md_use),
    .md_stall (md_stall),
    .busy     (busy),
    .md_out   (md_out),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // The stall unit must keep every op away from E while a result is pending.
  always @(negedge clk) begin
    if (!reset && busy && md_sel != OP_NONE)
      check("op_while_busy", 64'(md_sel), 64'd0);
  end

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    md_sel = op;
    d1 = v;
    @(posedge clk);
    #1 md_sel = OP_NONE;
    #1;
  endtask

  // Launch one op, return busy-cycle count and stall-cycle count (start cycle included).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nb, output int ns);
    md_sel = op;
    d1 = a;
    d2 = b;
    #1;
    ns = int'(md_stall);
    nb = 0;
    @(posedge clk);
    #1 md_sel = OP_NONE;
    #1;
    while (busy && nb < 40) begin
      nb++;
      ns += int'(md_stall);
      @(posedge clk);
      #2;
    end
  endtask

  int nb;
  int ns;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(md_stall), 64'd0);
    check("rst_md_out", 64'(md_out), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, nb, ns);
    check("mult_busy_cycles", 64'(nb), 64'd5);
    check("mult_hi", 64'(hi), 64'hFFFFFFFF);
    check("mult_lo", 64'(lo), 64'hFFFFFFFA);

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, nb, ns);
    check("multu_hi", 64'(hi), 64'h1);
    check("multu_lo", 64'(lo), 64'hFFFFFFFE);

    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, nb, ns);
    check("div_busy_cycles", 64'(nb), 64'd10);
    check("div_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_hi", 64'(hi), 64'hFFFFFFFF);

    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, nb, ns);
    check("div_ovf_lo", 64'(lo), 64'h80000000);
    check("div_ovf_hi", 64'(hi), 64'h0);

    mt(OP_MTHI, 32'h12345678);
    check("mthi_busy", 64'(busy), 64'd0);
    mt(OP_MTLO, 32'h12345678);
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mtlo_lo", 64'(lo), 64'h12345678);

    run_op(OP_DIVU, 32'd99, 32'd0, nb, ns);
    check("divu0_busy_cycles", 64'(nb), 64'd10);
    check("divu0_hi", 64'(hi), 64'h12345678);
    check("divu0_lo", 64'(lo), 64'h12345678);

    D_md_use = 1'b1;
    run_op(OP_MULT, 32'h00010000, 32'h00030000, nb, ns);
    check("stall_cycles", 64'(ns), 64'd6);
    check("stall_after", 64'(md_stall), 64'd0);
    md_sel = OP_MFHI;
    #1 check("mfhi_out", 64'(md_out), 64'h3);
    md_sel = OP_MFLO;
    #1 check("mflo_out", 64'(md_out), 64'h0);
    md_sel = OP_NONE;
    #1 check("none_out", 64'(md_out), 64'h0);
    run_op(OP_MULTU, 32'd5, 32'd5, nb, ns);
    check("b2b_busy_cycles", 64'(nb), 64'd5);
    check("b2b_lo", 64'(lo), 64'd25);
    check("b2b_hi", 64'(hi), 64'd0);
    D_md_use = 1'b0;

    md_sel = OP_DIV;
    d1 = 32'd100;
    d2 = 32'd7;
    @(posedge clk);
    #1 md_sel = OP_NONE;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op(OP_MULT, 32'd4, 32'd5, nb, ns);
    check("post_rst_busy_cycles", 64'(nb), 64'd5);
    check("post_rst_lo", 64'(lo), 64'd20);
    check("post_rst_hi", 64'(hi), 64'd0);

`ifdef MDU_MADD_EN
    mt(OP_MTHI, 32'd0);
    mt(OP_MTLO, 32'hFFFFFFFF);
    run_op(OP_MADDU, 32'd1, 32'd1, nb, ns);
    check("maddu_busy_cycles", 64'(nb), 64'd5);
    check("maddu_hi", 64'(hi), 64'h1);
    check("maddu_lo", 64'(lo), 64'h0);
    run_op(OP_MSUB, 32'hFFFFFFFF, 32'd1, nb, ns);
    check("msub_hi", 64'(hi), 64'h1);
    check("msub_lo", 64'(lo), 64'h1);
`else
    D_md_use = 1'b1;
    md_sel = OP_MADD;
    d1 = 32'd3;
    d2 = 32'd3;
    #1 check("madd_off_stall", 64'(md_stall), 64'd0);
    @(posedge clk);
    #1 md_sel = OP_NONE;
    D_md_use = 1'b0;
    #1;
    check("madd_off_busy", 64'(busy), 64'd0);
    check("madd_off_hi", 64'(hi), 64'd0);
    check("madd_off_lo", 64'(lo), 64'd20);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide sequencer for the E stage of the 5-stage pipeline.
- Decodes the E-stage md_sel code and launches mult/div operations.
- Counts the fixed latency of each operation, then commits the result to HI/LO.
- Serves mfhi/mflo reads and mthi/mtlo writes, and drives md_stall so the stall unit holds D-stage MDU instructions while a result is pending.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (and madd family); legal range 1..15.
- DIV_LAT, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- md_sel  in  4  E-stage MDU op code; already zero while E is bubbled by stall
- d1  in  32  forwarded rs value
- d2  in  32  forwarded rt value
- D_md_use  in  1  D-stage instruction is any MDU op (mult/div/mf*/mt*/madd*)
- md_stall  out  1  request a stall of the D stage
- busy  out  1  a mult/div is in flight
- md_out  out  32  mfhi/mflo read data
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register

Behaviour:
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12; codes 13-15 are treated as NONE.
- start = (md_sel in {1,2,3,4,9-12}) & (state==IDLE).
- Reset: state=IDLE, cnt=0, hi=lo=0, busy=0, md_stall=0; md_out follows hi/lo (0). Reset mid-operation aborts the op with no HI/LO write.
- FSM states: IDLE, MUL, DIV.
- IDLE, start on a mult-class op: on the edge, latch the 64-bit result into pend_hi/pend_lo, cnt=MULT_LAT-1, go to MUL.
- IDLE, start on a div op: same as mult, but cnt=DIV_LAT-1 and go to DIV.
- MUL/DIV:
  - cnt decrements every cycle.
  - On the edge where cnt==0: hi<=pend_hi, lo<=pend_lo, go to IDLE.
  - busy=1 for exactly LAT cycles, starting the cycle after start.
  - The new HI/LO is visible on the first cycle busy=0.
- md_stall = D_md_use & (start | busy). Combinational, so a D-stage mfhi directly behind a mult stalls in the same cycle start is seen.
- MTHI/MTLO in IDLE: hi (or lo) <= d1 on the next edge; single-cycle, busy stays 0.
- Any op while busy: ignored, with no state change. The stall unit prevents this; the bench asserts it never occurs.
- md_out is combinational: MFHI -> hi, MFLO -> lo, otherwise 0.
- MULT: signed 32x32 -> 64, {hi,lo}. MULTU: unsigned 32x32 -> 64.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- DIV, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (DIV/DIVU): full DIV_LAT busy, HI/LO left unchanged at the end.
- Back-to-back mult/div: the second start is legal on the first IDLE cycle after completion.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MADD/MADDU: {hi,lo} <= {hi,lo} + product, using signed/unsigned product respectively.
  - MSUB/MSUBU: {hi,lo} <= {hi,lo} - product, using signed/unsigned product respectively.
  - Accumulation is mod 2^64, latency MULT_LAT.
  - The accumulation base is hi/lo as sampled at start.
- Undefined: codes 9-12 are treated as NONE (no start, no stall contribution beyond D_md_use).

Decomposition:
- Shared constants header: md_sel op codes, MULT_LAT/DIV_LAT defaults, state encodings.
- Sub-module md_arith (combinational):
  - Inputs: op, d1, d2, hi, lo.
  - Outputs: pend_hi, pend_lo.
  - Covers signed/unsigned product, division with its corner cases, and the madd family.
- md_sched owns the FSM, counter, HI/LO registers, stall and read muxing.

Test Plan:
- MULT d1=0xFFFFFFFE (-2), d2=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU d1=0xFFFFFFFF, d2=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV d1=-7, d2=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU by 0 with hi=lo=0x12345678 preloaded via MTHI/MTLO -> both unchanged.
- MULT then D_md_use=1 (mfhi) every cycle -> md_stall=1 on the start cycle plus 5 busy cycles, then 0; md_out=hi under MFHI.
- Reset asserted at busy cycle 3 of DIV -> next cycle state IDLE, busy=0, hi=lo=0; a new MULT 4*5 then completes with lo=20.
- MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU d1=1, d2=1 -> hi=1, lo=0. Without the macro, md_sel=9 -> busy stays 0 and hi/lo unchanged.
